fwft_packet_framer: RTL and testbench



---
 rtl/fwft_packet_framer.sv | 175 +++++++++++++++++
 tb/tb_fwft_packet_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_packet_framer.sv
// fwft_packet_framer: turns first-word-fall-through FIFO words into a 32-bit
// valid/ready stream. It adds one trailer word per packet that carries the
// forwarded word count and the error flags. It drops orphan words and
// enforces a maximum packet length of MAX_WORDS.
// Optional feature macro: FWFT_FRAMER_CHECKSUM_EN. When it is defined, the
// trailer [15:0] carries the XOR fold of the forwarded payload words.
//
// state   | meaning
// IDLE    | waiting for a start word; non-start words are dropped as orphans
// DATA    | forwarding payload words of the current packet
// DISCARD | packet exceeded MAX_WORDS; popping and dropping until last
// TRAILER | emitting the trailer word when the output slot frees up
module fwft_packet_framer #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] err_orphan_cnt,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [1:0] {IDLE, DATA, DISCARD, TRAILER} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   count, count_nx;
    logic               trunc, trunc_nx;
    logic               ovf, ovf_nx;
    logic               fwd, drop_orphan, load_trailer;
    logic               slot_free;
    logic               head_start, head_last;
    logic [15:0]        ck_field;
    logic [31:0]        trailer;
    logic               unused_rsvd;

    assign slot_free   = !out_valid || out_ready;
    assign head_start  = fifo_dout[32];
    assign head_last   = fifo_dout[33];
    assign unused_rsvd = ^fifo_dout[35:34];
    assign trailer     = {trunc, ovf, count, ck_field};

    // Next-state, pop and forward decisions
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        trunc_nx     = trunc;
        ovf_nx       = ovf;
        fifo_rd_en   = 1'b0;
        fwd          = 1'b0;
        drop_orphan  = 1'b0;
        load_trailer = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_rd_en = 1'b1;
                    if (head_start) begin
                        fwd      = 1'b1;
                        count_nx = CNT_W'(1);
                        state_nx = head_last ? TRAILER : DATA;
                    end else begin
                        drop_orphan = 1'b1;
                    end
                end
            end
            DATA: begin
                if (!fifo_empty && slot_free) begin
                    if (head_start) begin
                        // The start word stays in the FIFO; IDLE picks it up after the trailer.
                        trunc_nx = 1'b1;
                        state_nx = TRAILER;
                    end else begin
                        fifo_rd_en = 1'b1;
                        if (count == CNT_W'(MAX_WORDS)) begin
                            ovf_nx   = 1'b1;
                            state_nx = head_last ? TRAILER : DISCARD;
                        end else begin
                            fwd      = 1'b1;
                            count_nx = count + CNT_W'(1);
                            if (head_last) state_nx = TRAILER;
                        end
                    end
                end
            end
            DISCARD: begin
                if (!fifo_empty && slot_free) begin
                    if (head_start) begin
                        trunc_nx = 1'b1;
                        state_nx = TRAILER;
                    end else begin
                        fifo_rd_en = 1'b1;
                        if (head_last) state_nx = TRAILER;
                    end
                end
            end
            default: begin
                if (slot_free) begin
                    load_trailer = 1'b1;
                    count_nx     = '0;
                    trunc_nx     = 1'b0;
                    ovf_nx       = 1'b0;
                    state_nx     = IDLE;
                end
            end
        endcase
    end

`ifdef FWFT_FRAMER_CHECKSUM_EN
    logic [15:0] cksum, cksum_nx;

    // Running XOR fold of forwarded payload words, cleared as the trailer leaves
    always_comb begin
        cksum_nx = cksum;
        if (load_trailer)
            cksum_nx = 16'h0000;
        else if (fwd)
            cksum_nx = cksum ^ fifo_dout[31:16] ^ fifo_dout[15:0];
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (rst) cksum <= 16'h0000;
        else     cksum <= cksum_nx;
    end

    assign ck_field = cksum;
`else
    assign ck_field = 16'h0000;
`endif

    // State, packet bookkeeping, output register and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            trunc          <= 1'b0;
            ovf            <= 1'b0;
            out_data       <= 32'h0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            err_orphan_cnt <= 16'h0;
            pkt_cnt        <= 16'h0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            trunc <= trunc_nx;
            ovf   <= ovf_nx;
            if (slot_free) begin
                if (fwd) begin
                    out_data  <= fifo_dout[31:0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end else if (load_trailer) begin
                    out_data  <= trailer;
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
            if (drop_orphan && err_orphan_cnt != 16'hFFFF)
                err_orphan_cnt <= err_orphan_cnt + 16'h1;
            if (load_trailer)
                pkt_cnt <= pkt_cnt + 16'h1;
        end
    end

endmodule

// File: tb/tb_fwft_packet_framer.sv
// Directed bench for fwft_packet_framer. Instance a uses the default MAX_WORDS.
// Instance b uses MAX_WORDS=2 for the length-limit scenario.
module tb_fwft_packet_framer;

`ifdef FWFT_FRAMER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;

    logic [35:0] fifo_dout_a = '0, fifo_dout_b = '0;
    logic        fifo_empty_a = 1'b1, fifo_empty_b = 1'b1;
    logic        fifo_rd_en_a, fifo_rd_en_b;
    logic [31:0] out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b, out_last_a, out_last_b;
    logic [15:0] err_orphan_cnt_a, err_orphan_cnt_b, pkt_cnt_a, pkt_cnt_b;

    logic [35:0] fq_a[$], fq_b[$];
    logic [32:0] oq_a[$], oq_b[$];
    int          pops_a = 0, pops_b = 0;
    int          n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    fwft_packet_framer dut_a (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout_a), .fifo_empty(fifo_empty_a),
        .fifo_rd_en(fifo_rd_en_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_last(out_last_a), .out_ready(out_ready),
        .err_orphan_cnt(err_orphan_cnt_a), .pkt_cnt(pkt_cnt_a)
    );

    fwft_packet_framer #(.MAX_WORDS(2)) dut_b (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout_b), .fifo_empty(fifo_empty_b),
        .fifo_rd_en(fifo_rd_en_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_last(out_last_b), .out_ready(out_ready),
        .err_orphan_cnt(err_orphan_cnt_b), .pkt_cnt(pkt_cnt_b)
    );

    // FIFO model pops and output capture use the values sampled at the edge
    always @(posedge clk) begin
        if (fifo_rd_en_a && fq_a.size() > 0) begin void'(fq_a.pop_front()); pops_a++; end
        if (fifo_rd_en_b && fq_b.size() > 0) begin void'(fq_b.pop_front()); pops_b++; end
        if (out_valid_a && out_ready) oq_a.push_back({out_last_a, out_data_a});
        if (out_valid_b && out_ready) oq_b.push_back({out_last_b, out_data_b});
    end

    // FIFO head is presented away from the active edge
    always @(negedge clk) begin
        fifo_empty_a = (fq_a.size() == 0);
        fifo_dout_a  = fifo_empty_a ? 36'h0 : fq_a[0];
        fifo_empty_b = (fq_b.size() == 0);
        fifo_dout_b  = fifo_empty_b ? 36'h0 : fq_b[0];
    end

    function automatic logic [35:0] w(input logic s, input logic l, input logic [31:0] d);
        return {2'b00, l, s, d};
    endfunction

    function automatic logic [15:0] fold(input logic [31:0] d);
        return d[31:16] ^ d[15:0];
    endfunction

    function automatic logic [32:0] trl(input logic t, input logic o, input int cnt,
                                        input logic [15:0] ck);
        return {1'b1, t, o, 14'(cnt), CK_EN ? ck : 16'h0000};
    endfunction

    task automatic wait_out(input bit sel_b, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel_b ? oq_b.size() : oq_a.size()) >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid_a); else n_pass++;
        n_checks++; if (out_last_a !== 1'b0) $display("FAIL reset_last got %b want 0", out_last_a); else n_pass++;
        n_checks++; if (out_data_a !== 32'h0) $display("FAIL reset_data got %h want 0", out_data_a); else n_pass++;
        n_checks++; if (fifo_rd_en_a !== 1'b0) $display("FAIL reset_rd_en got %b want 0", fifo_rd_en_a); else n_pass++;
        n_checks++; if (err_orphan_cnt_a !== 16'h0) $display("FAIL reset_orphan got %0d want 0", err_orphan_cnt_a); else n_pass++;
        n_checks++; if (pkt_cnt_a !== 16'h0) $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt_a); else n_pass++;
    endtask

    task automatic test_basic();
        logic [32:0] exp[4];
        int base;
        bit ok;
        base = oq_a.size();
        fq_a.push_back(w(1, 0, 32'h11111111));
        fq_a.push_back(w(0, 0, 32'h22222222));
        fq_a.push_back(w(0, 1, 32'h33333333));
        exp[0] = {1'b0, 32'h11111111};
        exp[1] = {1'b0, 32'h22222222};
        exp[2] = {1'b0, 32'h33333333};
        exp[3] = trl(0, 0, 3, fold(32'h11111111) ^ fold(32'h22222222) ^ fold(32'h33333333));
        wait_out(0, base + 4, ok);
        n_checks++; if (!ok) $display("FAIL basic_timeout got %0d words want 4", oq_a.size() - base); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (oq_a[base+i] !== exp[i]) $display("FAIL basic_word%0d got %h want %h", i, oq_a[base+i], exp[i]);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++; if (pkt_cnt_a !== 16'd1) $display("FAIL basic_pkt_cnt got %0d want 1", pkt_cnt_a); else n_pass++;
    endtask

    task automatic test_orphan();
        int base, pb;
        base = oq_a.size(); pb = pops_a;
        fq_a.push_back(w(0, 0, 32'hDEAD0001));
        fq_a.push_back(w(0, 1, 32'hDEAD0002));
        repeat (6) @(negedge clk);
        n_checks++; if (pops_a - pb !== 2) $display("FAIL orphan_pops got %0d want 2", pops_a - pb); else n_pass++;
        n_checks++; if (oq_a.size() !== base) $display("FAIL orphan_emitted got %0d want 0", oq_a.size() - base); else n_pass++;
        n_checks++; if (err_orphan_cnt_a !== 16'd2) $display("FAIL orphan_cnt got %0d want 2", err_orphan_cnt_a); else n_pass++;
    endtask

    task automatic test_trunc();
        logic [32:0] exp[7];
        int base;
        bit ok;
        base = oq_a.size();
        fq_a.push_back(w(1, 0, 32'hA0000001));
        fq_a.push_back(w(0, 0, 32'hA0000002));
        fq_a.push_back(w(0, 0, 32'hA0000004));
        fq_a.push_back(w(1, 0, 32'hB0000010));
        fq_a.push_back(w(0, 1, 32'hB0000020));
        exp[0] = {1'b0, 32'hA0000001};
        exp[1] = {1'b0, 32'hA0000002};
        exp[2] = {1'b0, 32'hA0000004};
        exp[3] = trl(1, 0, 3, 16'hA000 ^ 16'h0007);
        exp[4] = {1'b0, 32'hB0000010};
        exp[5] = {1'b0, 32'hB0000020};
        exp[6] = trl(0, 0, 2, 16'h0000 ^ 16'h0030);
        wait_out(0, base + 7, ok);
        n_checks++; if (!ok) $display("FAIL trunc_timeout got %0d words want 7", oq_a.size() - base); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (oq_a[base+i] !== exp[i]) $display("FAIL trunc_word%0d got %h want %h", i, oq_a[base+i], exp[i]);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++; if (pkt_cnt_a !== 16'd3) $display("FAIL trunc_pkt_cnt got %0d want 3", pkt_cnt_a); else n_pass++;
    endtask

    task automatic test_stall();
        logic [32:0] exp[5];
        int base, pb;
        bit ok;
        base = oq_a.size(); pb = pops_a;
        out_ready = 1'b0;
        fq_a.push_back(w(1, 0, 32'h5A5A0001));
        fq_a.push_back(w(0, 0, 32'h5A5A0002));
        fq_a.push_back(w(0, 0, 32'h5A5A0003));
        fq_a.push_back(w(0, 1, 32'h5A5A0004));
        repeat (4) @(negedge clk);
        n_checks++; if (out_data_a !== 32'h5A5A0001 || out_valid_a !== 1'b1)
            $display("FAIL stall_hold1 got %h/%b want 5a5a0001/1", out_data_a, out_valid_a); else n_pass++;
        n_checks++; if (pops_a - pb !== 1) $display("FAIL stall_pops1 got %0d want 1", pops_a - pb); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (out_data_a !== 32'h5A5A0002 || out_last_a !== 1'b0)
                $display("FAIL stall_hold2_%0d got %h/%b want 5a5a0002/0", i, out_data_a, out_last_a); else n_pass++;
            n_checks++; if (pops_a - pb !== 2) $display("FAIL stall_pops2_%0d got %0d want 2", i, pops_a - pb); else n_pass++;
        end
        out_ready = 1'b1;
        exp[0] = {1'b0, 32'h5A5A0001};
        exp[1] = {1'b0, 32'h5A5A0002};
        exp[2] = {1'b0, 32'h5A5A0003};
        exp[3] = {1'b0, 32'h5A5A0004};
        exp[4] = trl(0, 0, 4, 16'h0004);
        wait_out(0, base + 5, ok);
        n_checks++; if (!ok) $display("FAIL stall_timeout got %0d words want 5", oq_a.size() - base); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (oq_a[base+i] !== exp[i]) $display("FAIL stall_word%0d got %h want %h", i, oq_a[base+i], exp[i]);
                else n_pass++;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++; if (oq_a.size() !== base + 5) $display("FAIL stall_count got %0d want 5", oq_a.size() - base); else n_pass++;
    endtask

    task automatic test_single_and_reset();
        int base;
        bit ok;
        base = oq_a.size();
        fq_a.push_back(w(1, 1, 32'hABCD1234));
        wait_out(0, base + 2, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout got %0d words want 2", oq_a.size() - base); else n_pass++;
        if (ok) begin
            n_checks++; if (oq_a[base] !== {1'b0, 32'hABCD1234})
                $display("FAIL single_word got %h want %h", oq_a[base], {1'b0, 32'hABCD1234}); else n_pass++;
            n_checks++; if (oq_a[base+1] !== trl(0, 0, 1, 16'hABCD ^ 16'h1234))
                $display("FAIL single_trailer got %h want %h", oq_a[base+1], trl(0, 0, 1, 16'hABCD ^ 16'h1234)); else n_pass++;
        end
        out_ready = 1'b0;
        fq_a.push_back(w(1, 0, 32'h77770001));
        repeat (4) @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b1) $display("FAIL midrst_pre_valid got %b want 1", out_valid_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid_a); else n_pass++;
        n_checks++; if (out_last_a !== 1'b0) $display("FAIL midrst_last got %b want 0", out_last_a); else n_pass++;
        rst = 1'b0;
        out_ready = 1'b1;
        base = oq_a.size();
        repeat (10) @(negedge clk);
        n_checks++; if (oq_a.size() !== base) $display("FAIL midrst_no_trailer got %0d words want 0", oq_a.size() - base); else n_pass++;
        n_checks++; if (pkt_cnt_a !== 16'd0) $display("FAIL midrst_pkt_cnt got %0d want 0", pkt_cnt_a); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [32:0] exp[3];
        int base, pb;
        bit ok;
        base = oq_b.size(); pb = pops_b;
        fq_b.push_back(w(1, 0, 32'h0F000001));
        fq_b.push_back(w(0, 0, 32'h0F000002));
        fq_b.push_back(w(0, 0, 32'h0F000003));
        fq_b.push_back(w(0, 0, 32'h0F000004));
        fq_b.push_back(w(0, 1, 32'h0F000005));
        exp[0] = {1'b0, 32'h0F000001};
        exp[1] = {1'b0, 32'h0F000002};
        exp[2] = trl(0, 1, 2, 16'h0003);
        wait_out(1, base + 3, ok);
        n_checks++; if (!ok) $display("FAIL ovf_timeout got %0d words want 3", oq_b.size() - base); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (oq_b[base+i] !== exp[i]) $display("FAIL ovf_word%0d got %h want %h", i, oq_b[base+i], exp[i]);
                else n_pass++;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++; if (pops_b - pb !== 5) $display("FAIL ovf_pops got %0d want 5", pops_b - pb); else n_pass++;
        n_checks++; if (oq_b.size() !== base + 3) $display("FAIL ovf_count got %0d want 3", oq_b.size() - base); else n_pass++;
        n_checks++; if (pkt_cnt_b !== 16'd1) $display("FAIL ovf_pkt_cnt got %0d want 1", pkt_cnt_b); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_orphan();
        test_trunc();
        test_stall();
        test_overflow();
        test_single_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
